// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, WIDTH iterations per request.
// Optional two's-complement operation is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction
`endif

  // The partial remainder stays below the divisor, so the low WIDTH bits of the
  // shifted value minus the divisor are exact whenever the subtract is taken.
  always_comb begin
    rem_sh = {rem_r, quo_r[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_r});
    rem_nx = ge ? (rem_sh[WIDTH-1:0] - dvs_r) : rem_sh[WIDTH-1:0];
    quo_nx = {quo_r[WIDTH-2:0], ge};
`ifdef SEQ_DIVIDER_SIGNED_EN
    dvd_mag = neg_if(dividend, dividend[WIDTH-1]);
    dvs_mag = neg_if(divisor, divisor[WIDTH-1]);
    quo_fin = neg_if(quo_nx, neg_q);
    rem_fin = neg_if(rem_nx, neg_r);
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
    quo_fin = quo_nx;
    rem_fin = rem_nx;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              done        <= 1'b0;
              div_by_zero <= 1'b0;
              cnt         <= CNT_W'(WIDTH);
              rem_r       <= '0;
              quo_r       <= dvd_mag;
              dvs_r       <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
              neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r       <= dividend[WIDTH-1];
`endif
            end
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        RUN: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          cnt   <= cnt - 1'b1;
          // Last iteration: publish the sign-corrected result as we leave RUN.
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= quo_fin;
            remainder <= rem_fin;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32); signed vectors are added
// when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp;
  int n_bad;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; returns 1 time unit after that edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Count remaining busy cycles, then check the done cycle and its results.
  task automatic wait_done(input string name, input int exp_busy, input logic [31:0] eq,
                           input logic [31:0] er, input logic ez);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n !== exp_busy) begin
      n_bad++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_busy);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done: got %b expected 1", name, done);
    end
    n_cmp++;
    if (quotient !== eq) begin
      n_bad++;
      $display("FAIL %s quotient: got %h expected %h", name, quotient, eq);
    end
    n_cmp++;
    if (remainder !== er) begin
      n_bad++;
      $display("FAIL %s remainder: got %h expected %h", name, remainder, er);
    end
    n_cmp++;
    if (div_by_zero !== ez) begin
      n_bad++;
      $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, ez);
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      n_bad++;
      $display("FAIL %s outputs: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
               name, busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    dividend = 32'd100;
    divisor = 32'd7;
    tick();
    tick();
    check_zero("reset");
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_blocks_start: got busy=%b expected 0", busy);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    launch(32'd100, 32'd7);
    wait_done("div_100_7", 32, 32'd14, 32'd2, 1'b0);
    tick();
    n_cmp++;
    if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
      n_bad++;
      $display("FAIL hold_after_done: got done=%b q=%h r=%h expected 0/e/2", done, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    launch(32'h1234, 32'd0);
    wait_done("div_zero", 0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL div_zero_after: got done=%b busy=%b dz=%b expected 0/0/1", done, busy, div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    launch(32'd100, 32'd7);
    repeat (9) tick();
    dividend = 32'd5;
    divisor  = 32'd9;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done("ignore_start", 22, 32'd14, 32'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_back_start: got busy=%b done=%b expected 1/0", busy, done);
    end
    wait_done("div_max_1", 32, 32'hFFFF_FFFF, 32'd0, 1'b0);
    launch(32'd5, 32'd9);
    wait_done("div_5_9", 32, 32'd0, 32'd5, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_run();
    launch(32'd100, 32'd7);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_zero("after_reset_release");
    launch(32'd100, 32'd7);
    wait_done("div_after_reset", 32, 32'd14, 32'd2, 1'b0);
    tick();
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    launch(32'hFFFF_FF9C, 32'd7);
    wait_done("s_m100_7", 32, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    launch(32'd100, 32'hFFFF_FFF9);
    wait_done("s_100_m7", 32, 32'hFFFF_FFF2, 32'd2, 1'b0);
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("s_min_m1", 32, 32'h8000_0000, 32'd0, 1'b0);
    tick();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
